// File: rtl/sale_entry_pkg.sv
// Shared types and constants for the sale entry sequencer.
package sale_entry_pkg;

    // Bits per base-4 digit.
    localparam int unsigned DIGIT_BITS = 2;

    // Bit positions within CMD_En.
    localparam int unsigned CMD_ENTER  = 0;
    localparam int unsigned CMD_BACK   = 1;
    localparam int unsigned CMD_CLEAR  = 2;
    localparam int unsigned CMD_CANCEL = 3;

    // Entry state; encoding 3 is unused and recovers to S_ITEM.
    typedef enum logic [1:0] {
        S_ITEM = 2'd0,
        S_QTY  = 2'd1,
        S_SEND = 2'd2
    } state_e;

    // One-hot key pulse to digit value; only called with exactly one bit set.
    function automatic logic [DIGIT_BITS-1:0] key_to_digit(input logic [3:0] key);
        logic [DIGIT_BITS-1:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (key[i]) d = DIGIT_BITS'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/sale_entry_field.sv
// Base-4 digit accumulator: push shifts a digit in, pop drops the last one.
module sale_entry_field
    import sale_entry_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clr,
    input  logic [DIGIT_BITS-1:0]            digit,
    output logic [DIGIT_BITS*DIGITS-1:0]     value,
    output logic [$clog2(DIGITS):0]          count,
    output logic [DIGIT_BITS*DIGITS-1:0]     value_next,
    output logic [$clog2(DIGITS):0]          count_next,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned VW = DIGIT_BITS * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS) + 1;

    assign full  = (count == CW'(DIGITS));
    assign empty = (count == '0);

    // Next value/count; clear has priority, push/pop are guarded by full/empty.
    always_comb begin
        value_next = value;
        count_next = count;
        if (clr) begin
            value_next = '0;
            count_next = '0;
        end else if (push && !full) begin
            value_next = (value << DIGIT_BITS) | VW'(digit);
            count_next = count + CW'(1);
        end else if (pop && !empty) begin
            value_next = value >> DIGIT_BITS;
            count_next = count - CW'(1);
        end
    end

    // Field storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else begin
            value <= value_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/sale_entry_sequencer.sv
// Builds item/quantity sale requests from debounced key and command pulses.
module sale_entry_sequencer
    import sale_entry_pkg::*;
#(
    parameter int unsigned ITEM_DIGITS    = 3,
    parameter int unsigned QTY_DIGITS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic [3:0]                    KEY_En,
    input  logic [3:0]                    CMD_En,
    output logic                          Req_Valid,
    input  logic                          Req_Ready,
    output logic [2*ITEM_DIGITS-1:0]      Req_Item,
    output logic [2*QTY_DIGITS-1:0]       Req_Qty,
    output logic [((ITEM_DIGITS > QTY_DIGITS) ? 2*ITEM_DIGITS : 2*QTY_DIGITS)-1:0] Entry_Value,
    output logic [$clog2((ITEM_DIGITS > QTY_DIGITS) ? ITEM_DIGITS : QTY_DIGITS):0] Entry_Count,
    output logic [1:0]                    Entry_State,
    output logic                          Err_Pulse,
    output logic                          Timeout_Pulse
);

    localparam int unsigned IW   = 2 * ITEM_DIGITS;
    localparam int unsigned QW   = 2 * QTY_DIGITS;
    localparam int unsigned MAXD = (ITEM_DIGITS > QTY_DIGITS) ? ITEM_DIGITS : QTY_DIGITS;
    localparam int unsigned EW   = (IW > QW) ? IW : QW;
    localparam int unsigned ECW  = $clog2(MAXD) + 1;
    localparam int unsigned ICW  = $clog2(ITEM_DIGITS) + 1;
    localparam int unsigned QCW  = $clog2(QTY_DIGITS) + 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                err_d, tmo_d;
    logic                req_load, req_clear;
    logic [IW-1:0]       req_item_d;
    logic [QW-1:0]       req_qty_d;
    logic [EW-1:0]       entry_value_d;
    logic [ECW-1:0]      entry_count_d;

    logic [7:0]          in_bits;
    logic                in_any, in_multi, counting;
    logic [DIGIT_BITS-1:0] digit;

    logic                item_push, item_pop, item_clr, item_full, item_empty;
    logic                qty_push, qty_pop, qty_clr, qty_full, qty_empty;
    logic [IW-1:0]       item_value, item_value_next;
    logic [ICW-1:0]      item_count, item_count_next;
    logic [QW-1:0]       qty_value, qty_value_next;
    logic [QCW-1:0]      qty_count, qty_count_next;

    sale_entry_field #(.DIGITS(ITEM_DIGITS)) u_item (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .push       (item_push),
        .pop        (item_pop),
        .clr        (item_clr),
        .digit      (digit),
        .value      (item_value),
        .count      (item_count),
        .value_next (item_value_next),
        .count_next (item_count_next),
        .full       (item_full),
        .empty      (item_empty)
    );

    sale_entry_field #(.DIGITS(QTY_DIGITS)) u_qty (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .push       (qty_push),
        .pop        (qty_pop),
        .clr        (qty_clr),
        .digit      (digit),
        .value      (qty_value),
        .count      (qty_count),
        .value_next (qty_value_next),
        .count_next (qty_count_next),
        .full       (qty_full),
        .empty      (qty_empty)
    );

    assign in_bits  = {CMD_En, KEY_En};
    assign in_any   = |in_bits;
    assign in_multi = |(in_bits & (in_bits - 8'd1));
    assign digit    = key_to_digit(KEY_En);
    assign counting = (state_q == S_QTY) || ((state_q == S_ITEM) && !item_empty);

    // Decode the pulse against the current state into field ops and next state.
    always_comb begin
        logic is_item, cur_full, cur_empty;
        state_d   = state_q;
        timer_d   = '0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        req_load  = 1'b0;
        req_clear = 1'b0;
        item_push = 1'b0;
        item_pop  = 1'b0;
        item_clr  = 1'b0;
        qty_push  = 1'b0;
        qty_pop   = 1'b0;
        qty_clr   = 1'b0;
        is_item   = (state_q == S_ITEM);
        cur_full  = is_item ? item_full  : qty_full;
        cur_empty = is_item ? item_empty : qty_empty;

        unique case (state_q)
            S_ITEM, S_QTY: begin
                if (in_multi) begin
                    err_d = 1'b1;
                end else if (|KEY_En) begin
                    if (cur_full)     err_d     = 1'b1;
                    else if (is_item) item_push = 1'b1;
                    else              qty_push  = 1'b1;
                end else if (CMD_En[CMD_BACK]) begin
                    if (cur_empty)    err_d    = 1'b1;
                    else if (is_item) item_pop = 1'b1;
                    else              qty_pop  = 1'b1;
                end else if (CMD_En[CMD_CLEAR]) begin
                    if (is_item) item_clr = 1'b1;
                    else         qty_clr  = 1'b1;
                end else if (CMD_En[CMD_CANCEL]) begin
                    item_clr = 1'b1;
                    qty_clr  = 1'b1;
                    state_d  = S_ITEM;
                end else if (CMD_En[CMD_ENTER]) begin
                    if (is_item) begin
                        if (item_empty) begin
                            err_d = 1'b1;
                        end else begin
                            qty_clr = 1'b1;
                            state_d = S_QTY;
                        end
                    end else if (qty_empty || (qty_value == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        req_load = 1'b1;
                        state_d  = S_SEND;
                    end
                end else if (counting) begin
                    // A pulse on the expiry cycle takes the branches above instead.
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d    = 1'b1;
                        item_clr = 1'b1;
                        qty_clr  = 1'b1;
                        state_d  = S_ITEM;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_SEND: begin
                if (Req_Ready) begin
                    req_clear = 1'b1;
                    item_clr  = 1'b1;
                    qty_clr   = 1'b1;
                    state_d   = S_ITEM;
                end
            end
            default: begin
                item_clr = 1'b1;
                qty_clr  = 1'b1;
                state_d  = S_ITEM;
            end
        endcase
    end

    // Request payload and display values as they will be after this edge.
    always_comb begin
        req_item_d = Req_Item;
        req_qty_d  = Req_Qty;
        if (req_load) begin
            req_item_d = item_value;
            req_qty_d  = qty_value;
        end else if (req_clear) begin
            req_item_d = '0;
            req_qty_d  = '0;
        end
        unique case (state_d)
            S_QTY: begin
                entry_value_d = EW'(qty_value_next);
                entry_count_d = ECW'(qty_count_next);
            end
            S_SEND: begin
                entry_value_d = EW'(req_qty_d);
                entry_count_d = ECW'(QTY_DIGITS);
            end
            default: begin
                entry_value_d = EW'(item_value_next);
                entry_count_d = ECW'(item_count_next);
            end
        endcase
    end

    // State, timer and all registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_ITEM;
            timer_q       <= '0;
            Req_Valid     <= 1'b0;
            Req_Item      <= '0;
            Req_Qty       <= '0;
            Entry_Value   <= '0;
            Entry_Count   <= '0;
            Err_Pulse     <= 1'b0;
            Timeout_Pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            Req_Valid     <= (state_d == S_SEND);
            Req_Item      <= req_item_d;
            Req_Qty       <= req_qty_d;
            Entry_Value   <= entry_value_d;
            Entry_Count   <= entry_count_d;
            Err_Pulse     <= err_d;
            Timeout_Pulse <= tmo_d;
        end
    end

    assign Entry_State = state_q;

endmodule
